imem_arbiter: RTL and testbench

- Shares the single instruction-memory port between two requesters: the core fetch path (read-only) and the program loader (read/write), used to preload or inspect program words.
- Sequences each access through a fixed memory latency: grant, then wait, then a one-cycle response.
- Sits between the fetch/loader logic and the instruction memory; the memory does its own word indexing from the byte address.

---
 rtl/imem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_imem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Arbitrates the instruction-memory port between core fetch (read-only) and the program loader (read/write).
// Define IMEM_ALIGN_CHK_EN to add f_err_o/l_err_o and short-circuit misaligned accesses.
`timescale 1ns/1ps
module imem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              f_req_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    output logic              f_gnt_o,
    output logic              f_rvalid_o,
    output logic [DATA_W-1:0] f_rdata_o,
    input  logic              l_req_i,
    input  logic              l_we_i,
    input  logic [ADDR_W-1:0] l_addr_i,
    input  logic [DATA_W-1:0] l_wdata_i,
    output logic              l_gnt_o,
    output logic              l_rvalid_o,
    output logic [DATA_W-1:0] l_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
`ifdef IMEM_ALIGN_CHK_EN
    ,
    output logic              f_err_o,
    output logic              l_err_o
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic              owner_l_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] f_rdata_q;
    logic [DATA_W-1:0] l_rdata_q;
    logic [2:0]        cnt_q;
    logic [SW-1:0]     starve_q;
    logic [SW-1:0]     starve_d;
    logic              f_rvalid_q;
    logic              l_rvalid_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic              busy_q;
    logic              f_gnt_d;
    logic              l_gnt_d;
    logic              misalign_d;
    logic [ADDR_W-1:0] sel_addr_d;
`ifdef IMEM_ALIGN_CHK_EN
    logic              f_err_q;
    logic              l_err_q;
`endif

    // Winner selection: fetch by default, loader when alone or once fetch has starved it long enough
    always_comb begin
        f_gnt_d = 1'b0;
        l_gnt_d = 1'b0;
        if (!rst_i && state_q == S_IDLE) begin
            if (l_req_i && (!f_req_i || starve_q == SW'(STARVE_MAX))) begin
                l_gnt_d = 1'b1;
            end else begin
                f_gnt_d = f_req_i;
            end
        end else begin
            f_gnt_d = 1'b0;
            l_gnt_d = 1'b0;
        end
    end

    // Selected address, alignment check and starvation counter next state
    always_comb begin
        sel_addr_d = l_gnt_d ? l_addr_i : f_addr_i;
`ifdef IMEM_ALIGN_CHK_EN
        misalign_d = (sel_addr_d[1:0] != 2'b00);
`else
        misalign_d = 1'b0;
`endif
        starve_d = starve_q;
        if (!l_req_i || l_gnt_d) begin
            starve_d = '0;
        end else if (f_gnt_d && starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Access sequencer: grant latches the request, WAIT drives memory, DONE returns the response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            owner_l_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            f_rdata_q  <= '0;
            l_rdata_q  <= '0;
            cnt_q      <= 3'd0;
            starve_q   <= '0;
            f_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifdef IMEM_ALIGN_CHK_EN
            f_err_q    <= 1'b0;
            l_err_q    <= 1'b0;
`endif
        end else begin
            starve_q <= starve_d;
            case (state_q)
                S_IDLE: begin
                    if (f_gnt_d || l_gnt_d) begin
                        owner_l_q <= l_gnt_d;
                        addr_q    <= sel_addr_d;
                        wdata_q   <= l_gnt_d ? l_wdata_i : '0;
                        we_q      <= l_gnt_d & l_we_i;
                        cnt_q     <= 3'(MEM_LAT - 1);
                        busy_q    <= 1'b1;
                        if (misalign_d) begin
                            // Misaligned: answer with an error without touching memory
                            state_q    <= S_DONE;
                            f_rvalid_q <= f_gnt_d;
                            l_rvalid_q <= l_gnt_d;
                            if (l_gnt_d) begin
                                l_rdata_q <= '0;
                            end else begin
                                f_rdata_q <= '0;
                            end
`ifdef IMEM_ALIGN_CHK_EN
                            f_err_q    <= f_gnt_d;
                            l_err_q    <= l_gnt_d;
`endif
                        end else begin
                            state_q  <= S_WAIT;
                            mem_en_q <= 1'b1;
                            mem_we_q <= l_gnt_d & l_we_i;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q  <= S_DONE;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (owner_l_q) begin
                            l_rvalid_q <= 1'b1;
                            l_rdata_q  <= we_q ? '0 : mem_rdata_i;
                        end else begin
                            f_rvalid_q <= 1'b1;
                            f_rdata_q  <= mem_rdata_i;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    f_rvalid_q <= 1'b0;
                    l_rvalid_q <= 1'b0;
                    busy_q     <= 1'b0;
`ifdef IMEM_ALIGN_CHK_EN
                    f_err_q    <= 1'b0;
                    l_err_q    <= 1'b0;
`endif
                end
                default: begin
                    state_q    <= S_IDLE;
                    f_rvalid_q <= 1'b0;
                    l_rvalid_q <= 1'b0;
                    mem_en_q   <= 1'b0;
                    mem_we_q   <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign f_gnt_o     = f_gnt_d;
    assign l_gnt_o     = l_gnt_d;
    assign f_rvalid_o  = f_rvalid_q;
    assign l_rvalid_o  = l_rvalid_q;
    assign f_rdata_o   = f_rdata_q;
    assign l_rdata_o   = l_rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = busy_q;
`ifdef IMEM_ALIGN_CHK_EN
    assign f_err_o     = f_err_q;
    assign l_err_o     = l_err_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: three instances (MEM_LAT 1, 3, 7) sharing one stimulus.
`timescale 1ns/1ps
module tb_imem_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mem_clr, f_req, l_req, l_we;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        f_gnt [3], l_gnt [3], f_rv [3], l_rv [3], men [3], mwe [3], busy [3];
    logic [31:0] f_rd [3], l_rd [3], maddr [3], mwd [3], mrd [3];
`ifdef IMEM_ALIGN_CHK_EN
    logic        f_err [3], l_err [3];
`endif

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    int          n_chk = 0;
    int          n_err = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        imem_arbiter #(
            .ADDR_W(32), .DATA_W(32),
            .MEM_LAT((k == 0) ? 1 : ((k == 1) ? 3 : 7)),
            .STARVE_MAX(SMAX)
        ) u_dut (
            .clk_i(clk), .rst_i(rst),
            .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt[k]),
            .f_rvalid_o(f_rv[k]), .f_rdata_o(f_rd[k]),
            .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
            .l_gnt_o(l_gnt[k]), .l_rvalid_o(l_rv[k]), .l_rdata_o(l_rd[k]),
            .mem_en_o(men[k]), .mem_we_o(mwe[k]), .mem_addr_o(maddr[k]),
            .mem_wdata_o(mwd[k]), .mem_rdata_i(mrd[k]),
            .busy_o(busy[k])
`ifdef IMEM_ALIGN_CHK_EN
            , .f_err_o(f_err[k]), .l_err_o(l_err[k])
`endif
        );
        if (k == 0) begin : g_mem
            assign mrd[k] = mem[maddr[k][7:2]];
        end else begin : g_pat
            assign mrd[k] = ~maddr[k];
        end
    end

    // Behavioural memory behind instance 0
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (men[0] && mwe[0]) begin
            mem[maddr[0][7:2]] <= mwd[0];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1; mem_clr = 1'b1; f_req = 1'b0; l_req = 1'b0;
        tick; tick;
        rst = 1'b0; mem_clr = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    endtask

    typedef struct {
        bit          f_req;
        bit          l_req;
        bit          l_we;
        logic [31:0] f_addr;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        bit          exp_l;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt [8];

    task automatic run_vec(input vec_t v);
        logic [31:0] ea;
        logic        ew;
        ea = v.exp_l ? v.l_addr : v.f_addr;
        ew = v.exp_l & v.l_we;
        f_req = v.f_req; l_req = v.l_req; l_we = v.l_we;
        f_addr = v.f_addr; l_addr = v.l_addr; l_wdata = v.l_wdata;
        #1;
        chk("gnt_f", f_gnt[0], !v.exp_l);
        chk("gnt_l", l_gnt[0], v.exp_l);
        tick; f_req = 1'b0; l_req = 1'b0; #1;
        chk("wait_en", men[0], 1'b1);
        chk("wait_we", mwe[0], ew);
        chk("wait_addr", maddr[0], ea);
        if (ew) chk("wait_wdata", mwd[0], v.l_wdata);
        tick; #1;
        chk("done_en", men[0], 1'b0);
        chk("rv_f", f_rv[0], !v.exp_l);
        chk("rv_l", l_rv[0], v.exp_l);
        chk("rdata", v.exp_l ? l_rd[0] : f_rd[0], v.exp_rdata);
`ifdef IMEM_ALIGN_CHK_EN
        chk("err_clear", {f_err[0], l_err[0]}, 2'b00);
`endif
        tick; #1;
        chk("idle_busy", busy[0], 1'b0);
    endtask

    string order;
    int    dbl, gcount, rv_seen;
    int    gt [3][3];
    int    gn [3];
    int    lat [3];

    initial begin
        lat[0] = 1; lat[1] = 3; lat[2] = 7;
        f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
        f_addr = 32'h0; l_addr = 32'h0; l_wdata = 32'h0;
        rst = 1'b0; mem_clr = 1'b0;
        tick;
        do_reset;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_ctl", {busy[k], f_rv[k], l_rv[k], men[k], mwe[k], f_gnt[k], l_gnt[k]}, 7'h0);
            chk("reset_data", f_rd[k] | l_rd[k] | maddr[k] | mwd[k], 32'h0);
        end

        // Directed single transactions on the MEM_LAT=1 instance
        vt[0] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h8,  32'h00A00093, 1'b1, 32'h0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 32'h8,  32'h0,  32'h0,        1'b0, 32'h00A00093};
        vt[2] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h14, 32'h00100113, 1'b1, 32'h0};
        vt[3] = '{1'b1, 1'b0, 1'b0, 32'h14, 32'h0,  32'h0,        1'b0, 32'h00100113};
        vt[4] = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h14, 32'h0,        1'b1, 32'h00100113};
        vt[5] = '{1'b1, 1'b1, 1'b0, 32'h8,  32'h14, 32'h0,        1'b0, 32'h00A00093};
        vt[6] = '{1'b1, 1'b1, 1'b1, 32'h14, 32'h20, 32'hCAFEF00D, 1'b0, 32'h00100113};
        vt[7] = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h20, 32'h0,        1'b1, 32'h0};
        tick;
        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // Both requesters held continuously: loader must win every fifth grant
        do_reset;
        f_req = 1'b1; l_req = 1'b1; l_we = 1'b0; f_addr = 32'h0; l_addr = 32'h4;
        order = ""; dbl = 0; gcount = 0;
        for (int c = 0; c < 200 && gcount < 10; c++) begin
            #1;
            if (f_gnt[0] && l_gnt[0]) dbl++;
            if (f_gnt[0]) begin order = {order, "F"}; gcount++; end
            if (l_gnt[0]) begin order = {order, "L"}; gcount++; end
            tick;
        end
        n_chk++;
        if (order != "FFFFLFFFFL") begin
            n_err++;
            $display("FAIL grant_order: got %s expected FFFFLFFFFL", order);
        end
        chk("no_dbl_gnt", dbl, 0);

        // Back-to-back fetch spacing on every latency
        do_reset;
        f_req = 1'b1; f_addr = 32'h10; l_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            gn[k] = 0;
            for (int j = 0; j < 3; j++) gt[k][j] = -1000;
        end
        for (int c = 0; c < 40; c++) begin
            #1;
            for (int k = 0; k < 3; k++) begin
                if (f_gnt[k] && gn[k] < 3) begin gt[k][gn[k]] = c; gn[k]++; end
            end
            tick;
        end
        for (int k = 0; k < 3; k++) begin
            chk("spacing_a", gt[k][1] - gt[k][0], lat[k] + 2);
            chk("spacing_b", gt[k][2] - gt[k][1], lat[k] + 2);
        end

        // Reset in the middle of a MEM_LAT=3 access
        do_reset;
        f_req = 1'b1; f_addr = 32'h4; #1;
        chk("rst_gnt", f_gnt[1], 1'b1);
        tick; f_req = 1'b0; #1;
        chk("rst_wait_en", men[1], 1'b1);
        tick; #2; rst = 1'b1; #1;
        chk("rst_outs", {busy[1], f_rv[1], l_rv[1], men[1], mwe[1], f_gnt[1], l_gnt[1]}, 7'h0);
        chk("rst_data", maddr[1] | f_rd[1] | l_rd[1] | mwd[1], 32'h0);
        tick; rst = 1'b0; rv_seen = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (f_rv[1] || l_rv[1] || busy[1]) rv_seen++;
            tick;
        end
        chk("no_rv_after_rst", rv_seen, 0);

`ifdef IMEM_ALIGN_CHK_EN
        do_reset;
        run_vec('{1'b0, 1'b1, 1'b1, 32'h0, 32'h4, 32'h11111111, 1'b1, 32'h0});
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h6; l_wdata = 32'hDEADBEEF; #1;
        chk("mis_gnt", l_gnt[0], 1'b1);
        tick; l_req = 1'b0; #1;
        chk("mis_rv", {l_rv[0], l_err[0], men[0], busy[0]}, 4'b1101);
        chk("mis_rdata", l_rd[0], 32'h0);
        tick; #1;
        chk("mis_after", {l_rv[0], l_err[0], busy[0]}, 3'b000);
        run_vec('{1'b0, 1'b1, 1'b0, 32'h0, 32'h4, 32'h0, 1'b1, 32'h11111111});
`endif

        // Randomized traffic against a transaction-timeline reference
        do_reset;
        begin
            int  g, rv_at, starve;
            bit  rv_l, e_fg, e_lg, drop_f, drop_l, e_we, exp_busy, exp_en;
            logic [31:0] rv_d, e_addr;
            g = -100; rv_at = -1; starve = 0; rv_l = 1'b0; rv_d = 32'h0;
            drop_f = 1'b0; drop_l = 1'b0; e_we = 1'b0; e_addr = 32'h0;
            for (int cyc = 0; cyc < 800; cyc++) begin
                if (drop_f) f_req = 1'b0;
                if (drop_l) l_req = 1'b0;
                if (!f_req && $urandom_range(2) == 0) begin
                    f_req = 1'b1; f_addr = $urandom_range(63) << 2;
                end
                if (!l_req && $urandom_range(3) == 0) begin
                    l_req = 1'b1; l_we = 1'($urandom_range(1));
                    l_addr = $urandom_range(63) << 2; l_wdata = $urandom;
                end
                #1;
                exp_busy = (cyc > g) && (cyc < g + lat[0] + 2);
                exp_en   = (cyc > g) && (cyc <= g + lat[0]);
                chk("rnd_busy", busy[0], exp_busy);
                chk("rnd_en", men[0], exp_en);
                if (exp_en) begin
                    chk("rnd_addr", maddr[0], e_addr);
                    chk("rnd_we", mwe[0], e_we);
                end
                chk("rnd_rv_f", f_rv[0], (cyc == rv_at) && !rv_l);
                chk("rnd_rv_l", l_rv[0], (cyc == rv_at) && rv_l);
                if (cyc == rv_at) chk("rnd_rdata", rv_l ? l_rd[0] : f_rd[0], rv_d);
                e_fg = 1'b0; e_lg = 1'b0;
                if (cyc >= g + lat[0] + 2) begin
                    if (l_req && (!f_req || starve == SMAX)) e_lg = 1'b1;
                    else e_fg = f_req;
                end
                chk("rnd_gnt_f", f_gnt[0], e_fg);
                chk("rnd_gnt_l", l_gnt[0], e_lg);
                if (e_fg || e_lg) begin
                    g = cyc; rv_at = cyc + lat[0] + 1; rv_l = e_lg;
                    e_addr = e_lg ? l_addr : f_addr;
                    e_we = e_lg && l_we;
                    if (e_lg && l_we) begin
                        ref_mem[l_addr[7:2]] = l_wdata; rv_d = 32'h0;
                    end else begin
                        rv_d = ref_mem[e_addr[7:2]];
                    end
                end
                if (!l_req || e_lg) starve = 0;
                else if (e_fg && starve < SMAX) starve++;
                drop_f = e_fg; drop_l = e_lg;
                tick;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
